// File: rtl/cobs_serial_tx.sv
// cobs_serial_tx
//
// Purpose:
//   Takes a frame of raw bytes from a valid/ready stream and COBS-encodes it
//   in groups of up to 254 non-zero bytes. The encoded stream, followed by a
//   0x00 frame delimiter, is shifted out on TXD as 8N1 UART with no idle gaps
//   between bytes of the same frame.
//
// Ports:
//   CLK       in   clock
//   RST       in   synchronous reset, active low
//   IN_VALID  in   IN_DATA / IN_LAST are valid
//   IN_DATA   in   raw payload byte (0x00 allowed)
//   IN_LAST   in   IN_DATA is the final byte of the frame
//   IN_READY  out  a byte is accepted this cycle when IN_VALID is also high
//   TXD       out  UART line, idles high
//   BUSY      out  high from the first accepted byte until the delimiter's
//                  stop bit has completed
module cobs_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 116
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       IN_LAST,
  output logic       IN_READY,
  output logic       TXD,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    ENC_FILL,
    ENC_EMIT_CODE,
    ENC_EMIT_DATA,
    ENC_EMIT_DELIM,
    ENC_WAIT_DELIM
  } enc_state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  // Group buffer holding the non-zero bytes of the group being built.
  logic [7:0] grp_mem [0:253];

  enc_state_t  enc_state_q,  enc_state_d;
  logic [7:0]  cnt_q,        cnt_d;
  logic [7:0]  code_q,       code_d;
  logic [7:0]  idx_q,        idx_d;
  logic        last_q,       last_d;
  logic        zero_last_q,  zero_last_d;
  logic        busy_q,       busy_d;
  logic        in_ready_q,   in_ready_d;

  uart_state_t uart_state_q, uart_state_d;
  logic [15:0] baud_cnt_q,   baud_cnt_d;
  logic [3:0]  bit_cnt_q,    bit_cnt_d;
  logic [7:0]  shift_q,      shift_d;
  logic        uart_delim_q, uart_delim_d;
  logic        txd_q,        txd_d;

  logic       accept;
  logic       mem_we;
  logic       baud_last;
  logic       uart_ready;
  logic       tx_valid;
  logic       tx_fire;
  logic       delim_done;
  logic       group_done;
  logic [7:0] tx_byte;

  assign IN_READY = in_ready_q;
  assign TXD      = txd_q;
  assign BUSY     = busy_q;

  // Handshake between the encoder and the UART. The UART can take a new byte
  // while idle or in the final cycle of a stop bit, which is what makes
  // consecutive bytes leave the line back to back.
  always_comb begin
    accept     = IN_VALID && in_ready_q;
    baud_last  = (baud_cnt_q == BAUD_LAST);
    uart_ready = (uart_state_q == UART_IDLE) ||
                 ((uart_state_q == UART_STOP) && baud_last);
    tx_valid   = (enc_state_q == ENC_EMIT_CODE) ||
                 (enc_state_q == ENC_EMIT_DATA) ||
                 (enc_state_q == ENC_EMIT_DELIM);
    tx_fire    = tx_valid && uart_ready;
    delim_done = (uart_state_q == UART_STOP) && baud_last && uart_delim_q;
  end

  // Byte offered to the UART in each emitting state.
  always_comb begin
    tx_byte = 8'h00;
    case (enc_state_q)
      ENC_EMIT_CODE: tx_byte = code_q;
      ENC_EMIT_DATA: tx_byte = grp_mem[idx_q];
      default:       tx_byte = 8'h00;
    endcase
  end

  // Encoder next-state logic: build a group, then hand its code byte and data
  // bytes to the UART one at a time.
  always_comb begin
    enc_state_d = enc_state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    idx_d       = idx_q;
    last_d      = last_q;
    zero_last_d = zero_last_q;
    busy_d      = busy_q;
    mem_we      = 1'b0;
    group_done  = 1'b0;

    case (enc_state_q)
      ENC_FILL: begin
        if (accept) begin
          busy_d = 1'b1;
          idx_d  = 8'd0;
          if (IN_DATA != 8'h00) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == 8'd253) begin
              // A full group carries no implied zero, so a frame ending here
              // needs no trailing 0x01 group.
              code_d      = 8'hFF;
              last_d      = IN_LAST;
              zero_last_d = 1'b0;
              enc_state_d = ENC_EMIT_CODE;
            end else if (IN_LAST) begin
              code_d      = cnt_q + 8'd2;
              last_d      = 1'b1;
              zero_last_d = 1'b0;
              enc_state_d = ENC_EMIT_CODE;
            end
          end else begin
            // A trailing zero still needs an empty group after this one.
            code_d      = cnt_q + 8'd1;
            last_d      = IN_LAST;
            zero_last_d = IN_LAST;
            enc_state_d = ENC_EMIT_CODE;
          end
        end
      end

      ENC_EMIT_CODE: begin
        if (tx_fire) begin
          if (code_q == 8'd1) begin
            group_done = 1'b1;
          end else begin
            enc_state_d = ENC_EMIT_DATA;
          end
        end
      end

      ENC_EMIT_DATA: begin
        if (tx_fire) begin
          if ((idx_q + 8'd2) == code_q) begin
            group_done = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      ENC_EMIT_DELIM: begin
        if (tx_fire) begin
          enc_state_d = ENC_WAIT_DELIM;
        end
      end

      ENC_WAIT_DELIM: begin
        // Hold the input off until the delimiter has fully left the line so
        // BUSY and IN_READY never overlap two frames.
        if (delim_done) begin
          enc_state_d = ENC_FILL;
          cnt_d       = 8'd0;
          last_d      = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: enc_state_d = ENC_FILL;
    endcase

    if (group_done) begin
      idx_d = 8'd0;
      if (!last_q) begin
        enc_state_d = ENC_FILL;
        cnt_d       = 8'd0;
      end else if (zero_last_q) begin
        // Reuse the code path to send the empty 0x01 group.
        code_d      = 8'd1;
        zero_last_d = 1'b0;
        enc_state_d = ENC_EMIT_CODE;
      end else begin
        enc_state_d = ENC_EMIT_DELIM;
      end
    end

    in_ready_d = (enc_state_d == ENC_FILL);
  end

  // UART next-state logic: start bit, eight data bits LSB first, stop bit,
  // each held for CLKS_PER_BIT cycles. TXD is registered from txd_d.
  always_comb begin
    uart_state_d = uart_state_q;
    baud_cnt_d   = baud_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    uart_delim_d = uart_delim_q;
    txd_d        = txd_q;

    case (uart_state_q)
      UART_IDLE: begin
        txd_d      = 1'b1;
        baud_cnt_d = 16'd0;
      end

      UART_START: begin
        if (baud_last) begin
          uart_state_d = UART_DATA;
          baud_cnt_d   = 16'd0;
          bit_cnt_d    = 4'd0;
          txd_d        = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      UART_DATA: begin
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == 4'd7) begin
            uart_state_d = UART_STOP;
            txd_d        = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      UART_STOP: begin
        if (baud_last) begin
          uart_state_d = UART_IDLE;
          baud_cnt_d   = 16'd0;
          uart_delim_d = 1'b0;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      default: uart_state_d = UART_IDLE;
    endcase

    // A new byte overrides the stop-to-idle transition so the next start bit
    // follows the previous stop bit immediately.
    if (tx_fire) begin
      uart_state_d = UART_START;
      baud_cnt_d   = 16'd0;
      shift_d      = tx_byte;
      uart_delim_d = (enc_state_q == ENC_EMIT_DELIM);
      txd_d        = 1'b0;
    end
  end

  // State registers for both FSMs and the registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      enc_state_q  <= ENC_FILL;
      cnt_q        <= 8'd0;
      code_q       <= 8'd0;
      idx_q        <= 8'd0;
      last_q       <= 1'b0;
      zero_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      uart_state_q <= UART_IDLE;
      baud_cnt_q   <= 16'd0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      uart_delim_q <= 1'b0;
      txd_q        <= 1'b1;
    end else begin
      enc_state_q  <= enc_state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      zero_last_q  <= zero_last_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      uart_state_q <= uart_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      uart_delim_q <= uart_delim_d;
      txd_q        <= txd_d;
    end
  end

  // Group buffer write port; contents need no reset since cnt gates reads.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      grp_mem[cnt_q] <= IN_DATA;
    end
  end

endmodule

// File: doc/cobs_serial_tx.md
Name: cobs_serial_tx

Overview:
- Transmit-side counterpart to the serial receive path and its COBS decoder.
- Accepts a frame of raw bytes over a valid/ready stream and COBS-encodes it in groups of up to 254 non-zero bytes.
- Serializes the encoded stream, including the trailing 0x00 delimiter, onto TXD as 8N1 UART.
- Sits between the host-bound data sources (framebuffer readback, status) and the FPGA TX pin.

Parameters:
- CLKS_PER_BIT, 116: CLK cycles per UART bit; applies to start, data and stop bits.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- IN_VALID  in  1  IN_DATA/IN_LAST valid
- IN_DATA  in  8  raw payload byte (0x00 allowed)
- IN_LAST  in  1  byte is the final byte of the frame
- IN_READY  out  1  block accepts a byte this cycle
- TXD  out  1  UART line, idle high
- BUSY  out  1  frame in progress (first byte accepted until delimiter stop bit completes)

Behaviour:
- Reset (RST=0 at a CLK edge):
  - TXD=1, IN_READY=0, BUSY=0.
  - Group count=0; both FSMs return to their idle states.
  - Applies mid-frame or mid-bit: the partial frame is discarded with no trailing bits sent.
  - IN_READY=1 on the first cycle after RST returns high.
- Transfer: a byte is taken only when IN_VALID & IN_READY at the CLK edge. With IN_READY=0, IN_VALID is ignored.
- Buffer: 254x8 group buffer; cnt 0..254 holds the number of buffered non-zero bytes.
- Encoder FSM:
  - FILL: IN_READY=1. On an accepted byte:
    - Non-zero: write buf[cnt], cnt+1.
    - Zero: close the group with code=cnt+1; the zero itself is not stored.
    - The group also closes when cnt reaches 254 (code=0xFF), or when IN_LAST is set (code=cnt+1 after storing the byte if it is non-zero).
    - IN_READY drops the cycle after the closing byte.
  - EMIT_CODE: send the code byte.
  - EMIT_DATA: send buf[0..code-2] in order, then:
    - Frame not ended: cnt=0, go to FILL.
    - Frame ended with a non-zero last byte: go to EMIT_DELIM.
    - Last byte was 0x00: emit one extra group, code 0x01 with no data, then EMIT_DELIM.
  - 0xFF group boundary: a full 254 group adds no implied zero. If its closing byte carries IN_LAST, go straight to EMIT_DELIM, with no trailing 0x01 group.
  - EMIT_DELIM: send 0x00, then cnt=0 and go to FILL. BUSY falls on the cycle after the delimiter's stop bit ends.
- UART FSM (IDLE, START, DATA, STOP):
  - Loads a byte from the encoder when in IDLE.
  - Sends a start bit 0, 8 data bits LSB first, then a stop bit 1, each held for exactly CLKS_PER_BIT cycles.
  - Back-to-back: the next byte's start bit begins on the cycle right after the previous stop bit ends. There are no idle gaps inside a frame.
  - Byte period is exactly 10*CLKS_PER_BIT cycles.
- Simultaneous events:
  - A closing byte accepted on the same edge as cnt=253→254 closes the group once, with code 0xFF.
  - IN_LAST on a zero byte in a full-count group can never occur, since the group closes at 254 first.
- Widths: cnt 8-bit, bit counter 4-bit, baud counter 16-bit; no wrap permitted (CLKS_PER_BIT ≤ 65535).
- Empty frames are impossible: IN_LAST always accompanies a byte.

Test Plan:
- Frame 11,22 (LAST on 22) → line bytes 03 11 22 00. BUSY high from acceptance through the final stop bit.
- Frame 11,00,22 → 02 11 02 22 00. Frame 00 (LAST) → 01 01 00.
- 254 bytes 01..FE (LAST on FE) → FF 01..FE 00. 255 bytes 01..FF → FF 01..FE 02 FF 00. IN_READY must be low throughout each group emission.
- CLKS_PER_BIT=4, frame 03 (LAST): first line byte 02 shows TXD 0×4, then 0,1,0,0,0,0,0,0 each ×4, then 1×4. The next byte starts on the very next cycle.
- Hold IN_VALID=1 while IN_READY=0 with changing IN_DATA → no extra bytes appear in the encoded output.
- Assert RST=0 mid data bit of the second byte → next cycle TXD=1, BUSY=0, IN_READY=0. After release, the frame 05 encodes cleanly as 02 05 00.
